shift_pattern_checker: RTL and testbench

Receive-side checker for the bouncing one-hot LED pattern from the shift counter. The 8-bit pattern walks up from 0x01 to 0x80, walks back down to 0x02, and repeats with a 14-sample period. This block samples the pattern, decodes the lit position and direction, locks onto the sequence phase and flags any sample that breaks the sequence. It sits downstream of the pattern generator, or on a looped-back LED bus, as a self-check monitor.

---
 rtl/shift_pkg.sv | 31 +++
 rtl/onehot_pos_encoder.sv | 31 +++
 rtl/shift_pattern_checker.sv | 205 ++++++++++++++++++++
 tb/tb_shift_pattern_checker.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types, constants and pattern helper for the shift pattern checker
//
// Purpose: tracker state encoding, default width/period constants and the
// reference pattern function used to predict the next sample.
// Ports: none (package).

package shift_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } shift_state_e;

  localparam int SHIFT_W       = 8;
  localparam int SHIFT_P       = 2 * SHIFT_W - 2;
  localparam int SHIFT_PHASE_W = $clog2(SHIFT_P);

  // Bouncing one-hot value at a given phase for a w-bit pattern.
  // Rising half lights bit phase, falling half lights bit (period - phase).
  function automatic logic [63:0] expected_pattern(input int phase, input int w);
    int p;
    p = 2 * w - 2;
    if (phase < w) begin
      expected_pattern = 64'd1 << phase;
    end else begin
      expected_pattern = 64'd1 << (p - phase);
    end
  endfunction

endpackage

// File: rtl/onehot_pos_encoder.sv
// rtl/onehot_pos_encoder.sv - combinational one-hot legality check and bit-index encoder
//
// Purpose: reports whether exactly one bit of the input is set and, if so,
// the index of that bit.
// Ports:
//   pattern   in  W        sampled pattern
//   pos       out clog2(W) index of the set bit (highest set bit if not one-hot)
//   is_onehot out 1        exactly one bit set

module onehot_pos_encoder #(
  parameter  int W     = 8,
  localparam int POS_W = $clog2(W)
) (
  input  logic [W-1:0]     pattern,
  output logic [POS_W-1:0] pos,
  output logic             is_onehot
);

  always_comb begin
    pos = '0;
    for (int i = 0; i < W; i++) begin
      if (pattern[i]) begin
        pos = POS_W'(i);
      end
    end
  end

  // Non-zero and clearing the lowest set bit leaves nothing.
  assign is_onehot = (pattern != '0) && ((pattern & (pattern - 1'b1)) == '0);

endmodule

// File: rtl/shift_pattern_checker.sv
// rtl/shift_pattern_checker.sv - lock-and-track checker for the bouncing one-hot LED pattern
//
// Purpose: decodes the lit position of each valid sample, resolves the
// sequence phase from two adjacent samples, declares lock after LOCK_COUNT
// correct transitions and pulses err when a locked sequence breaks.
// Optional feature macro: SHIFT_CHECK_ERR_COUNT_EN enables the saturating
// 8-bit error counter; without it err_count is tied to zero.
// Ports:
//   clk       in  1         rising-edge clock
//   reset     in  1         asynchronous active-high reset
//   in_valid  in  1         pattern carries a sample this cycle
//   pattern   in  W         observed pattern
//   pos       out clog2(W)  lit bit index of the last one-hot sample
//   dir_down  out 1         pattern moving toward bit 0
//   phase     out clog2(P)  phase of the last accepted sample
//   locked    out 1         tracking the sequence
//   err       out 1         one-cycle pulse on a broken locked sequence
//   err_count out 8         saturating error count

import shift_pkg::*;

module shift_pattern_checker #(
  parameter  int W          = SHIFT_W,
  parameter  int LOCK_COUNT = 3,
  localparam int P          = 2 * W - 2,
  localparam int POS_W      = $clog2(W),
  localparam int PH_W       = $clog2(P)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W-1:0]     pattern,
  output logic [POS_W-1:0] pos,
  output logic             dir_down,
  output logic [PH_W-1:0]  phase,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_count
);

  shift_state_e     state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_down_q, dir_down_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [3:0]       cnt_q, cnt_d;

  logic [POS_W-1:0] enc_pos;
  logic             enc_onehot;

  logic [PH_W-1:0]  phase_inc;
  logic [W-1:0]     exp_vec;
  logic             match;
  logic             adj_up;
  logic             adj_dn;
  int               ph_first;

  onehot_pos_encoder #(.W(W)) u_enc (
    .pattern   (pattern),
    .pos       (enc_pos),
    .is_onehot (enc_onehot)
  );

  always_comb begin
    phase_inc = (phase_q == PH_W'(P - 1)) ? '0 : phase_q + 1'b1;
    exp_vec   = W'(expected_pattern(int'(phase_inc), W));
    // The expected value is one-hot, so a match implies a legal sample.
    match     = (pattern == exp_vec);
    adj_up    = (int'(enc_pos) == int'(pos_q) + 1);
    adj_dn    = (int'(enc_pos) + 1 == int'(pos_q));
    // Falling onto bit 0 is phase 0 itself, not phase P.
    if (adj_up) begin
      ph_first = int'(enc_pos);
    end else if (enc_pos == '0) begin
      ph_first = 0;
    end else begin
      ph_first = P - int'(enc_pos);
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    dir_down_d = dir_down_q;
    phase_d    = phase_q;
    locked_d   = locked_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;

    if (in_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (enc_onehot) begin
            pos_d   = enc_pos;
            cnt_d   = '0;
            state_d = ST_CONFIRM;
          end
        end

        ST_CONFIRM: begin
          if (cnt_q == '0 && enc_onehot && (adj_up || adj_dn)) begin
            phase_d    = PH_W'(ph_first);
            dir_down_d = (ph_first >= W);
            pos_d      = enc_pos;
            cnt_d      = 4'd1;
            if (LOCK_COUNT == 1) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end
          end else if (cnt_q != '0 && match) begin
            phase_d    = phase_inc;
            dir_down_d = (int'(phase_inc) >= W);
            pos_d      = enc_pos;
            cnt_d      = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == 4'(LOCK_COUNT)) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end
          end else if (enc_onehot) begin
            // Restart confirmation anchored on this sample.
            pos_d = enc_pos;
            cnt_d = '0;
          end else begin
            state_d = ST_HUNT;
          end
        end

        ST_LOCKED: begin
          if (match) begin
            phase_d    = phase_inc;
            dir_down_d = (int'(phase_inc) >= W);
            pos_d      = enc_pos;
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            if (enc_onehot) begin
              // Treated as the first sample of a fresh hunt.
              pos_d   = enc_pos;
              cnt_d   = '0;
              state_d = ST_CONFIRM;
            end else begin
              state_d = ST_HUNT;
            end
          end
        end

        default: begin
          state_d  = ST_HUNT;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_HUNT;
      pos_q      <= '0;
      dir_down_q <= 1'b0;
      phase_q    <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      dir_down_q <= dir_down_d;
      phase_q    <= phase_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef SHIFT_CHECK_ERR_COUNT_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (err_d && err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

  assign pos      = pos_q;
  assign dir_down = dir_down_q;
  assign phase    = phase_q;
  assign locked   = locked_q;
  assign err      = err_q;

endmodule

// File: tb/tb_shift_pattern_checker.sv
// tb/tb_shift_pattern_checker.sv - randomized self-checking bench for shift_pattern_checker

module tb_shift_pattern_checker;

  localparam int W     = 8;
  localparam int LOCK  = 3;
  localparam int P     = 2 * W - 2;
  localparam int POS_W = $clog2(W);
  localparam int PH_W  = $clog2(P);

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [W-1:0]     pattern;
  logic [POS_W-1:0] pos;
  logic             dir_down;
  logic [PH_W-1:0]  phase;
  logic             locked;
  logic             err;
  logic [7:0]       err_count;

  shift_pattern_checker #(.W(W), .LOCK_COUNT(LOCK)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .pattern   (pattern),
    .pos       (pos),
    .dir_down  (dir_down),
    .phase     (phase),
    .locked    (locked),
    .err       (err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference sequence built by walking the LED up then back down.
  logic [W-1:0] seq [P];

  // Behavioural model: mode 0 hunting, 1 confirming, 2 locked.
  int m_mode, m_anchor, m_cnt, m_phase, m_pos, m_dir, m_locked, m_err, m_errcnt;

  task automatic model_reset();
    m_mode = 0; m_anchor = 0; m_cnt = 0; m_phase = 0;
    m_pos = 0; m_dir = 0; m_locked = 0; m_err = 0; m_errcnt = 0;
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] pat);
    bit legal;
    int b, nextp, found;
    m_err = 0;
    if (!v) return;
    legal = ($countones(pat) == 1);
    b     = legal ? $clog2(pat) : 0;
    nextp = (m_phase + 1) % P;
    if (m_mode == 2) begin
      if (pat == seq[nextp]) begin
        m_phase = nextp; m_pos = b; m_dir = (nextp >= W);
      end else begin
        m_err = 1; m_locked = 0;
`ifdef SHIFT_CHECK_ERR_COUNT_EN
        if (m_errcnt < 255) m_errcnt++;
`endif
        if (legal) begin m_pos = b; m_anchor = b; m_cnt = 0; m_mode = 1; end
        else m_mode = 0;
      end
    end else if (m_mode == 1) begin
      found = -1;
      if (m_cnt == 0 && legal) begin
        // Find the phase whose sample follows the anchor in the sequence.
        for (int p = 0; p < P; p++)
          if (seq[p] == pat && seq[(p + P - 1) % P] == W'(1 << m_anchor)) found = p;
      end else if (m_cnt > 0 && pat == seq[nextp]) begin
        found = nextp;
      end
      if (found >= 0) begin
        m_phase = found; m_pos = b; m_dir = (found >= W); m_cnt++;
        if (m_cnt == LOCK) begin m_mode = 2; m_locked = 1; end
      end else if (legal) begin
        m_pos = b; m_anchor = b; m_cnt = 0;
      end else begin
        m_mode = 0;
      end
    end else begin
      if (legal) begin m_pos = b; m_anchor = b; m_cnt = 0; m_mode = 1; end
    end
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".pos"},       32'(pos),       32'(m_pos));
    chk({ctx, ".dir_down"},  32'(dir_down),  32'(m_dir));
    chk({ctx, ".phase"},     32'(phase),     32'(m_phase));
    chk({ctx, ".locked"},    32'(locked),    32'(m_locked));
    chk({ctx, ".err"},       32'(err),       32'(m_err));
    chk({ctx, ".err_count"}, 32'(err_count), 32'(m_errcnt));
  endtask

  task automatic drive(input string ctx, input logic v, input logic [W-1:0] pat);
    @(negedge clk);
    in_valid = v;
    pattern  = v ? pat : W'($urandom);
    @(posedge clk);
    #1;
    model_step(v, pat);
    check_outputs(ctx);
  endtask

  int gen;  // generator phase of the next clean sample

  task automatic clean(input string ctx, input int n);
    for (int i = 0; i < n; i++) begin
      drive(ctx, 1'b1, seq[gen]);
      gen = (gen + 1) % P;
    end
  endtask

  initial begin
    int r;
    logic [W-1:0] v;
    for (int p = 0; p < P; p++) seq[p] = (p < W) ? W'(1 << p) : W'(1 << (P - p));

    reset = 1'b1; in_valid = 1'b0; pattern = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs("reset");

    // Clean stream, two full periods from 0x01.
    gen = 0;
    clean("clean", 2 * P);
    chk("clean_locked_end", 32'(locked), 32'd1);

    // Locked at phase 5; replace phase 6 with 0x08, then run clean again.
    while (gen != 6) clean("to_ph5", 1);
    drive("inj08", 1'b1, 8'h08);
    gen = 7;
    clean("after08", 2 * P);

    // Zero followed by a two-hot sample: only one error.
    drive("inj00", 1'b1, 8'h00);
    drive("inj18", 1'b1, 8'h18);
    clean("after18", P);

    // Gap of ten idle cycles while locked.
    for (int i = 0; i < 10; i++) drive("gap", 1'b0, '0);
    clean("resume", 4);

    // Start mid-sequence on a falling edge toward bit 0.
    drive("midbad", 1'b1, 8'hFF);
    drive("midbad2", 1'b1, 8'h00);
    drive("mid", 1'b1, 8'h04);
    gen = 13;
    clean("mid", 4);

    // Randomized mix of clean steps, corruptions, jumps and gaps.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        drive("rnd_gap", 1'b0, '0);
      end else if (r < 12) begin
        v = W'(1 << $urandom_range(0, W - 1));
        drive("rnd_hot", 1'b1, v);
        gen = (gen + 1) % P;
      end else if (r < 15) begin
        drive("rnd_zero", 1'b1, '0);
        gen = (gen + 1) % P;
      end else if (r < 18) begin
        v = W'($urandom);
        drive("rnd_any", 1'b1, v);
        gen = (gen + 1) % P;
      end else if (r < 20) begin
        gen = $urandom_range(0, P - 1);
        clean("rnd_jump", 1);
      end else begin
        clean("rnd_clean", 1);
      end
    end

    // Asynchronous reset between edges while locked.
    clean("pre_rst", P);
    chk("pre_rst_locked", 32'(locked), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("rst_held");
    @(negedge clk);
    reset = 1'b0;
    gen = 3;
    clean("post_rst", P + 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
